// File: rtl/mpu6050_sampler.sv
// Periodic MPU-6050 sampler: probes WHO_AM_I, then walks registers 0x3B..0x48
// through a single-register I2C read engine and publishes seven 16-bit words.
module mpu6050_sampler #(
  parameter int          SAMPLE_PERIOD  = 100_000_000,
  parameter int          TIMEOUT_CYCLES = 4_000_000,
  parameter logic [7:0]  WHO_AM_I_VAL   = 8'h68
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic [7:0]  rd_address,
  output logic        rd_start,
  input  logic [7:0]  rd_data,
  input  logic        rd_done,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic [15:0] temp,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        sample_valid,
  output logic        busy,
  output logic        id_error,
  output logic        timeout_error,
  output logic        overrun
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PERIOD_RELOAD = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST       = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    ADDR_WHO      = 8'h75;
  localparam logic [7:0]    ADDR_BASE     = 8'h3B;
  localparam logic [3:0]    LAST_IDX      = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE, S_PROBE_REQ, S_PROBE_WAIT, S_WAIT_TICK, S_REQ, S_WAIT, S_PUBLISH, S_FAULT
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [PW-1:0]        timer_q, timer_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [13:0][7:0]     shadow_q, shadow_d;
  logic [6:0][15:0]     words_q, words_d;
  logic [7:0]           rd_address_q, rd_address_d;
  logic                 rd_start_q, rd_start_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 busy_q, busy_d;
  logic                 id_error_q, id_error_d;
  logic                 timeout_error_q, timeout_error_d;
  logic                 overrun_q, overrun_d;
  logic                 timed_out;

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    timer_d         = (timer_q == '0) ? '0 : timer_q - 1'b1;
    tcnt_d          = tcnt_q;
    shadow_d        = shadow_q;
    words_d         = words_q;
    sample_valid_d  = 1'b0;
    id_error_d      = id_error_q;
    timeout_error_d = timeout_error_q;
    overrun_d       = overrun_q;
    // tcnt holds the number of cycles elapsed since the last rd_start
    timed_out       = (tcnt_q == TO_LAST) && !rd_done;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d         = S_PROBE_REQ;
          id_error_d      = 1'b0;
          timeout_error_d = 1'b0;
          overrun_d       = 1'b0;
        end
      end
      S_PROBE_REQ: begin
        tcnt_d  = TW'(1);
        state_d = S_PROBE_WAIT;
      end
      S_PROBE_WAIT: begin
        tcnt_d = (tcnt_q == TO_LAST) ? tcnt_q : tcnt_q + 1'b1;
        if (rd_done) begin
          if (!enable) begin
            state_d = S_IDLE;
          end else if (rd_data == WHO_AM_I_VAL) begin
            state_d = S_REQ;
            idx_d   = '0;
          end else begin
            state_d    = S_FAULT;
            id_error_d = 1'b1;
          end
        end else if (timed_out) begin
          timeout_error_d = 1'b1;
          state_d         = enable ? S_FAULT : S_IDLE;
        end
      end
      S_REQ: begin
        tcnt_d  = TW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tcnt_d = (tcnt_q == TO_LAST) ? tcnt_q : tcnt_q + 1'b1;
        if (rd_done) begin
          if (!enable) begin
            state_d = S_IDLE;
          end else begin
            shadow_d[idx_q] = rd_data;
            if (idx_q == LAST_IDX) begin
              state_d = S_PUBLISH;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_REQ;
            end
          end
        end else if (timed_out) begin
          timeout_error_d = 1'b1;
          state_d         = enable ? S_FAULT : S_IDLE;
        end
      end
      S_PUBLISH: begin
        for (int k = 0; k < 7; k++) words_d[k] = {shadow_q[2*k], shadow_q[2*k+1]};
        sample_valid_d = 1'b1;
        // Timer already expired here means the next start is late: burst exceeded the period
        if (timer_q == '0) overrun_d = 1'b1;
        state_d = enable ? S_WAIT_TICK : S_IDLE;
      end
      S_WAIT_TICK: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_REQ;
          idx_d   = '0;
        end
      end
      S_FAULT: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rd_start_d   = (state_d == S_PROBE_REQ) || (state_d == S_REQ);
    rd_address_d = rd_address_q;
    if (state_d == S_PROBE_REQ)  rd_address_d = ADDR_WHO;
    else if (state_d == S_REQ)   rd_address_d = ADDR_BASE + {4'h0, idx_d};
    if (state_d == S_REQ && idx_d == '0) timer_d = PERIOD_RELOAD;
    busy_d = (state_d != S_IDLE) && (state_d != S_FAULT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      timer_q         <= '0;
      tcnt_q          <= '0;
      shadow_q        <= '0;
      words_q         <= '0;
      rd_address_q    <= '0;
      rd_start_q      <= 1'b0;
      sample_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
      id_error_q      <= 1'b0;
      timeout_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      timer_q         <= timer_d;
      tcnt_q          <= tcnt_d;
      shadow_q        <= shadow_d;
      words_q         <= words_d;
      rd_address_q    <= rd_address_d;
      rd_start_q      <= rd_start_d;
      sample_valid_q  <= sample_valid_d;
      busy_q          <= busy_d;
      id_error_q      <= id_error_d;
      timeout_error_q <= timeout_error_d;
      overrun_q       <= overrun_d;
    end
  end

  assign rd_address    = rd_address_q;
  assign rd_start      = rd_start_q;
  assign accel_x       = words_q[0];
  assign accel_y       = words_q[1];
  assign accel_z       = words_q[2];
  assign temp          = words_q[3];
  assign gyro_x        = words_q[4];
  assign gyro_y        = words_q[5];
  assign gyro_z        = words_q[6];
  assign sample_valid  = sample_valid_q;
  assign busy          = busy_q;
  assign id_error      = id_error_q;
  assign timeout_error = timeout_error_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_mpu6050_sampler.sv
// Bench for mpu6050_sampler: behavioural read-engine model plus per-scenario checks.
module tb_mpu6050_sampler;
  localparam int P = 400;
  localparam int T = 100;

  logic        clock = 1'b0, reset_n = 1'b0, enable = 1'b0, rd_done = 1'b0;
  logic [7:0]  rd_data = 8'h00, rd_address;
  logic        rd_start, sample_valid, busy, id_error, timeout_error, overrun;
  logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;

  mpu6050_sampler #(.SAMPLE_PERIOD(P), .TIMEOUT_CYCLES(T), .WHO_AM_I_VAL(8'h68)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .rd_address(rd_address), .rd_start(rd_start), .rd_data(rd_data), .rd_done(rd_done),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp(temp),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .sample_valid(sample_valid), .busy(busy), .id_error(id_error),
    .timeout_error(timeout_error), .overrun(overrun));

  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  // engine model controls
  int         lat_min = 1, lat_max = 3;
  logic [7:0] probe_val = 8'h68;
  bit         fixed_data = 1'b1, withhold_en = 1'b0;
  logic [7:0] withhold_addr = 8'h00;
  logic [7:0] rbyte [14];
  int         addr_log[$], cyc_log[$];
  int         done_cyc = 0;

  initial begin
    for (int i = 0; i < 14; i++) rbyte[i] = 8'h00;
    forever begin
      @(negedge clock);
      rd_done = 1'b0;
      if (rd_start) begin
        int a, l;
        logic [7:0] d;
        a = int'(rd_address);
        addr_log.push_back(a);
        cyc_log.push_back(cyc);
        if (!(withhold_en && a == int'(withhold_addr))) begin
          l = $urandom_range(lat_max, lat_min);
          repeat (l) @(negedge clock);
          if (a == 'h75)      d = probe_val;
          else if (fixed_data) d = 8'(a - 'h3A);
          else                 d = 8'($urandom);
          if (a >= 'h3B && a <= 'h48) rbyte[a - 'h3B] = d;
          rd_data  = d;
          rd_done  = 1'b1;
          done_cyc = cyc;
        end
      end
    end
  end

  // sample word set predicted from the bytes the engine most recently returned
  function automatic logic [111:0] model_words();
    logic [111:0] m = '0;
    for (int i = 0; i < 14; i++) m = {m[103:0], rbyte[i]};
    return m;
  endfunction

  int            sv_count = 0, sv_multi = 0, word_glitch = 0, overlap_err = 0;
  int            sv_cyc[$];
  logic [111:0]  sv_got[$], sv_exp[$];
  int            busy_fall_cyc = 0, to_rise_cyc = 0;
  bit            outstanding = 0, prev_sv = 0, prev_busy = 0, prev_to = 0, prev_rst = 0;
  logic [111:0]  prev_words = '0;

  always @(negedge clock) begin
    logic [111:0] cur;
    #1;
    cur = {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z};
    if (!reset_n) begin
      outstanding = 0;
    end else begin
      if (rd_done || !busy) outstanding = 0;
      if (rd_start) begin
        if (outstanding) overlap_err++;
        outstanding = 1;
      end
      if (sample_valid) begin
        sv_count++;
        sv_cyc.push_back(cyc);
        sv_got.push_back(cur);
        sv_exp.push_back(model_words());
        if (prev_sv) sv_multi++;
      end
      if (prev_rst && cur != prev_words && !sample_valid) word_glitch++;
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      if (!prev_to && timeout_error) to_rise_cyc = cyc;
    end
    prev_sv = sample_valid; prev_busy = busy; prev_to = timeout_error;
    prev_rst = reset_n; prev_words = cur;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(int n);
    repeat (n) begin @(negedge clock); #2; end
  endtask

  task automatic wait_sv(int target, int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (sv_count >= target) begin ok = 1; break; end
      step(1);
    end
  endtask

  task automatic wait_idle(int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1; break; end
      step(1);
    end
  endtask

  task automatic wait_addr(int addr, int from, int budget, output bit ok, output int idx);
    ok = 0; idx = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      for (int j = from; j < addr_log.size(); j++)
        if (addr_log[j] == addr) begin ok = 1; idx = j; break; end
      if (!ok) step(1);
    end
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if ({accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z} !== 112'h0) begin
      failures++; $display("FAIL reset_words: got %h want 0", {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z});
    end
    checks++;
    if ({rd_address, rd_start, sample_valid, busy, id_error, timeout_error, overrun} !== 14'h0) begin
      failures++; $display("FAIL reset_ctrl: got %h want 0", {rd_address, rd_start, sample_valid, busy, id_error, timeout_error, overrun});
    end
    reset_n = 1'b1;
    step(5);
    checks++;
    if (busy !== 1'b0 || addr_log.size() != 0) begin
      failures++; $display("FAIL idle_hold: busy=%b starts=%0d want 0/0", busy, addr_log.size());
    end
  endtask

  task automatic test_basic_burst();
    int base = addr_log.size(), bsv = sv_count, busy_low = 0;
    bit ok = 0;
    logic [111:0] want = 112'h0102_0304_0506_0708_090A_0B0C_0D0E;
    fixed_data = 1; lat_min = 1; lat_max = 3; probe_val = 8'h68;
    enable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (!busy) busy_low++;
      if (sv_count > bsv) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_sv: no sample_valid within budget"); end
    checks++;
    if (addr_log.size() - base != 15) begin
      failures++; $display("FAIL basic_starts: got %0d want 15", addr_log.size() - base);
    end
    for (int i = 0; i < 15 && base + i < addr_log.size(); i++) begin
      int wa = (i == 0) ? 'h75 : 'h3A + i;
      checks++;
      if (addr_log[base + i] != wa) begin
        failures++; $display("FAIL basic_addr[%0d]: got %h want %h", i, addr_log[base + i], wa);
      end
    end
    if (ok) begin
      checks++;
      if (sv_got[bsv] !== want) begin
        failures++; $display("FAIL basic_words: got %h want %h", sv_got[bsv], want);
      end
    end
    checks++;
    if (busy_low != 0) begin failures++; $display("FAIL basic_busy: low for %0d cycles want 0", busy_low); end
    step(1);
    checks++;
    if (sample_valid !== 1'b0 || sv_multi != 0) begin
      failures++; $display("FAIL basic_sv_width: sv=%b multi=%0d want 0/0", sample_valid, sv_multi);
    end
    enable = 1'b0;
    wait_idle(200, ok);
  endtask

  task automatic test_random_periodic();
    int base = addr_log.size(), bsv = sv_count;
    int starts[$];
    bit ok;
    fixed_data = 0; lat_min = 1; lat_max = 6;
    enable = 1'b1;
    wait_sv(bsv + 3, 3000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL periodic_sv: got %0d samples want 3", sv_count - bsv); end
    for (int i = bsv; i < sv_count; i++) begin
      checks++;
      if (sv_got[i] !== sv_exp[i]) begin
        failures++; $display("FAIL periodic_words[%0d]: got %h want %h", i - bsv, sv_got[i], sv_exp[i]);
      end
    end
    for (int i = base; i < addr_log.size(); i++) if (addr_log[i] == 'h3B) starts.push_back(cyc_log[i]);
    for (int i = 1; i < starts.size(); i++) begin
      checks++;
      if (starts[i] - starts[i-1] != P) begin
        failures++; $display("FAIL periodic_interval: got %0d want %0d", starts[i] - starts[i-1], P);
      end
    end
    checks++;
    if (overrun !== 1'b0 || overlap_err != 0 || word_glitch != 0 || sv_multi != 0) begin
      failures++; $display("FAIL periodic_protocol: overrun=%b overlap=%0d glitch=%0d multi=%0d want 0", overrun, overlap_err, word_glitch, sv_multi);
    end
    enable = 1'b0;
    wait_idle(200, ok);
  endtask

  task automatic test_overrun();
    int base = addr_log.size(), bsv = sv_count;
    int starts[$];
    bit ok;
    lat_min = 40; lat_max = 40;
    enable = 1'b1;
    wait_sv(bsv + 2, 3000, ok);
    checks++;
    if (!ok || overrun !== 1'b1) begin
      failures++; $display("FAIL overrun_flag: got %b (samples %0d) want 1", overrun, sv_count - bsv);
    end
    for (int i = base; i < addr_log.size(); i++) if (addr_log[i] == 'h3B) starts.push_back(cyc_log[i]);
    // each register costs one request cycle plus 40 wait cycles, then PUBLISH and WAIT_TICK
    checks++;
    if (starts.size() < 2 || starts[1] - starts[0] != 14 * 41 + 2) begin
      failures++; $display("FAIL overrun_back_to_back: got %0d want %0d", (starts.size() < 2) ? -1 : starts[1] - starts[0], 14 * 41 + 2);
    end
    if (ok) begin
      checks++;
      if (sv_got[bsv + 1] !== sv_exp[bsv + 1]) begin
        failures++; $display("FAIL overrun_words: got %h want %h", sv_got[bsv + 1], sv_exp[bsv + 1]);
      end
    end
    enable = 1'b0;
    wait_idle(200, ok);
    step(2);
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_id_error();
    int base = addr_log.size(), b2, idx;
    bit ok = 0;
    lat_min = 1; lat_max = 3; probe_val = 8'h70;
    enable = 1'b1;
    step(2);
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    for (int i = 0; i < 50 && !ok; i++) begin if (id_error) ok = 1; else step(1); end
    step(1);
    checks++;
    if (id_error !== 1'b1 || busy !== 1'b0 || timeout_error !== 1'b0) begin
      failures++; $display("FAIL id_fault: id=%b busy=%b to=%b want 1/0/0", id_error, busy, timeout_error);
    end
    b2 = addr_log.size();
    step(30);
    checks++;
    if (addr_log.size() != b2 || b2 - base != 1 || addr_log[base] != 'h75) begin
      failures++; $display("FAIL id_no_restart: starts=%0d want 1 (probe only)", addr_log.size() - base);
    end
    enable = 1'b0;
    step(2);
    checks++;
    if (id_error !== 1'b1) begin failures++; $display("FAIL id_sticky: got %b want 1", id_error); end
    probe_val = 8'h68;
    enable = 1'b1;
    step(2);
    checks++;
    if (id_error !== 1'b0) begin failures++; $display("FAIL id_clear: got %b want 0", id_error); end
    wait_addr('h75, b2, 20, ok, idx);
    checks++;
    if (!ok) begin failures++; $display("FAIL id_reprobe: probe not reissued"); end
    enable = 1'b0;
    wait_idle(200, ok);
  endtask

  task automatic test_timeout();
    int bsv = sv_count, last;
    bit ok = 0;
    logic [111:0] prev;
    fixed_data = 0; lat_min = 1; lat_max = 4; withhold_en = 0;
    enable = 1'b1;
    wait_sv(bsv + 1, 1000, ok);
    prev = ok ? sv_got[bsv] : '0;
    withhold_addr = 8'h3F; withhold_en = 1;
    ok = 0;
    for (int i = 0; i < P + T + 300 && !ok; i++) begin if (timeout_error) ok = 1; else step(1); end
    step(1);
    checks++;
    if (!ok || busy !== 1'b0) begin failures++; $display("FAIL timeout_flag: to=%b busy=%b want 1/0", timeout_error, busy); end
    last = addr_log.size() - 1;
    checks++;
    if (addr_log[last] != 'h3F || to_rise_cyc - cyc_log[last] != T) begin
      failures++; $display("FAIL timeout_latency: addr=%h got %0d want %0d", addr_log[last], to_rise_cyc - cyc_log[last], T);
    end
    checks++;
    if ({accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z} !== prev || sv_count != bsv + 1) begin
      failures++; $display("FAIL timeout_hold: words=%h samples=%0d want %h/1", {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z}, sv_count - bsv, prev);
    end
    withhold_en = 0;
    enable = 1'b0;
    step(3);
    checks++;
    if (busy !== 1'b0 || timeout_error !== 1'b1) begin
      failures++; $display("FAIL timeout_exit: busy=%b to=%b want 0/1", busy, timeout_error);
    end
  endtask

  task automatic test_enable_drop();
    int base = addr_log.size(), bsv = sv_count, idx, n;
    bit ok;
    fixed_data = 0; lat_min = 5; lat_max = 5;
    enable = 1'b1;
    wait_addr('h41, base, 500, ok, idx);
    enable = 1'b0;
    n = addr_log.size();
    wait_idle(50, ok);
    checks++;
    if (!ok || busy_fall_cyc - done_cyc != 1) begin
      failures++; $display("FAIL drop_busy_fall: got %0d cycles after rd_done want 1", busy_fall_cyc - done_cyc);
    end
    step(10);
    checks++;
    if (sv_count != bsv || addr_log.size() != n || addr_log[n-1] != 'h41) begin
      failures++; $display("FAIL drop_no_publish: samples=%0d starts=%0d want 0/%0d", sv_count - bsv, addr_log.size(), n);
    end
  endtask

  task automatic test_async_reset();
    int bsv = sv_count, idx, n, rel;
    bit ok;
    fixed_data = 0; lat_min = 8; lat_max = 8;
    enable = 1'b1;
    wait_sv(bsv + 1, 1000, ok);
    wait_addr('h3D, addr_log.size(), 1000, ok, idx);
    step(2);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z, rd_start, sample_valid, busy} !== 115'h0) begin
      failures++; $display("FAIL async_reset: outputs not cleared immediately, busy=%b", busy);
    end
    enable = 1'b0;
    step(2);
    reset_n = 1'b1;
    rel = cyc; n = addr_log.size(); bsv = sv_count;
    step(15);
    checks++;
    if (done_cyc <= rel) begin failures++; $display("FAIL stray_done: last rd_done cyc %0d want > %0d", done_cyc, rel); end
    checks++;
    if (busy !== 1'b0 || sv_count != bsv || addr_log.size() != n ||
        {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z} !== 112'h0) begin
      failures++; $display("FAIL stray_ignored: busy=%b samples=%0d starts=%0d want idle", busy, sv_count - bsv, addr_log.size() - n);
    end
    checks++;
    if (overlap_err != 0 || sv_multi != 0) begin
      failures++; $display("FAIL protocol: overlap=%0d multi=%0d want 0/0", overlap_err, sv_multi);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_random_periodic();
    test_overrun();
    test_id_error();
    test_timeout();
    test_enable_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
